// File: rtl/trng_ctrl.sv
// Phase sequencer, bit packer and repetition-count health monitor for the NLFSR TRNG.
// Words are offered on a valid/ready slot that survives reseeds and only clears on rst.
module trng_ctrl #(
   parameter int WORD_W       = 32,
   parameter int LOAD_CYC     = 80,
   parameter int INIT_CYC     = 160,
   parameter int CE_DIV       = 4,
   parameter int RESEED_WORDS = 1024,
   parameter int REP_LIMIT    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              reseed,
   input  logic              warbler_i,
   output logic              load_en,
   output logic              init_en,
   output logic              run_en,
   output logic              nlfsr3_ce,
   output logic [WORD_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              hlth_fail,
   output logic [7:0]        fail_cnt
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_INIT = 2'd2;
   localparam logic [1:0] ST_RUN  = 2'd3;

   localparam int PH_MAX = (LOAD_CYC > INIT_CYC) ? LOAD_CYC : INIT_CYC;
   localparam int PH_W   = $clog2(PH_MAX + 1);
   localparam int DIV_W  = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
   localparam int BC_W   = $clog2(WORD_W + 1);
   localparam int WC_W   = $clog2(RESEED_WORDS + 1);
   localparam int RL_W   = $clog2(REP_LIMIT + 1);

   localparam logic [PH_W-1:0]  LOAD_LAST = PH_W'(LOAD_CYC - 1);
   localparam logic [PH_W-1:0]  INIT_LAST = PH_W'(INIT_CYC - 1);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CE_DIV - 1);
   localparam logic [BC_W-1:0]  BC_FULL   = BC_W'(WORD_W);
   localparam logic [BC_W-1:0]  BC_PENULT = BC_W'(WORD_W - 1);
   localparam logic [WC_W-1:0]  WC_LAST   = WC_W'(RESEED_WORDS - 1);
   localparam logic [RL_W-1:0]  REP_LAST  = RL_W'(REP_LIMIT - 1);

   logic [1:0]        state_reg, state_next;
   logic [PH_W-1:0]   phase_reg;
   logic [DIV_W-1:0]  div_reg;
   logic              ce_q_reg;
   logic [WORD_W-1:0] acc_reg;
   logic [WORD_W-1:0] acc_shift;
   logic [BC_W-1:0]   bit_cnt_reg;
   logic [WC_W-1:0]   word_cnt_reg;
   logic              last_bit_reg;
   logic [RL_W-1:0]   run_len_reg;
   logic [WORD_W-1:0] out_data_reg;
   logic              out_valid_reg;
   logic              hlth_fail_reg;
   logic [7:0]        fail_cnt_reg;

   logic in_run, cap_vld, acc_full, slot_busy, stall, rep_fail;
   logic transfer, budget_hit, stay_run;

   assign acc_shift[0] = warbler_i;
   for (genvar gi = 1; gi < WORD_W; gi++) begin : gen_shift
      assign acc_shift[gi] = acc_reg[gi-1];
   end

   assign in_run    = (state_reg == ST_RUN);
   assign cap_vld   = in_run & ce_q_reg;
   assign acc_full  = (bit_cnt_reg == BC_FULL);
   assign slot_busy = out_valid_reg & ~out_ready;
   // A capture still in flight into the last free bit counts as full, so no bit is ever dropped.
   assign stall     = slot_busy & (acc_full | ((bit_cnt_reg == BC_PENULT) & cap_vld));
   assign nlfsr3_ce = in_run & (div_reg == DIV_LAST) & ~stall;
   assign rep_fail  = cap_vld & (warbler_i == last_bit_reg) & (run_len_reg == REP_LAST);

   assign transfer   = in_run & en & ~reseed & ~rep_fail & acc_full & ~slot_busy;
   assign budget_hit = transfer & (word_cnt_reg == WC_LAST);

   always_comb begin
      state_next = state_reg;
      if (!en) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: state_next = ST_LOAD;
            ST_LOAD: if (phase_reg == LOAD_LAST) state_next = ST_INIT;
            ST_INIT: if (phase_reg == INIT_LAST) state_next = ST_RUN;
            default: if (reseed | rep_fail | budget_hit) state_next = ST_LOAD;
         endcase
      end
   end

   assign stay_run = in_run & (state_next == ST_RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         phase_reg <= '0;
         div_reg   <= '0;
         ce_q_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         ce_q_reg  <= nlfsr3_ce;
         if ((state_next != state_reg) || !((state_reg == ST_LOAD) || (state_reg == ST_INIT)))
            phase_reg <= '0;
         else
            phase_reg <= phase_reg + 1'b1;
         // The divider parks on its last count while stalled so ce fires as soon as the slot frees.
         if (!stay_run)
            div_reg <= '0;
         else if (div_reg == DIV_LAST)
            div_reg <= stall ? div_reg : '0;
         else
            div_reg <= div_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_reg      <= '0;
         bit_cnt_reg  <= '0;
         word_cnt_reg <= '0;
         last_bit_reg <= 1'b0;
         run_len_reg  <= '0;
      end else if (!stay_run) begin
         acc_reg      <= '0;
         bit_cnt_reg  <= '0;
         word_cnt_reg <= '0;
         last_bit_reg <= 1'b0;
         run_len_reg  <= '0;
      end else begin
         if (transfer)
            word_cnt_reg <= word_cnt_reg + 1'b1;
         if (cap_vld) begin
            acc_reg      <= transfer ? {{(WORD_W-1){1'b0}}, warbler_i} : acc_shift;
            bit_cnt_reg  <= transfer ? BC_W'(1) : bit_cnt_reg + 1'b1;
            last_bit_reg <= warbler_i;
            run_len_reg  <= (warbler_i == last_bit_reg) ? run_len_reg + 1'b1 : RL_W'(1);
         end else if (transfer) begin
            bit_cnt_reg <= '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
         hlth_fail_reg <= 1'b0;
         fail_cnt_reg  <= '0;
      end else begin
         if (transfer) begin
            out_data_reg  <= acc_reg;
            out_valid_reg <= 1'b1;
         end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
         end
         if (rep_fail) begin
            hlth_fail_reg <= 1'b1;
            if (fail_cnt_reg != 8'hFF)
               fail_cnt_reg <= fail_cnt_reg + 8'd1;
         end
      end
   end

   assign load_en   = (state_reg == ST_LOAD);
   assign init_en   = (state_reg == ST_INIT);
   assign run_en    = in_run;
   assign busy      = (state_reg != ST_IDLE);
   assign out_data  = out_data_reg;
   assign out_valid = out_valid_reg;
   assign hlth_fail = hlth_fail_reg;
   assign fail_cnt  = fail_cnt_reg;

endmodule

// File: tb/tb_trng_ctrl.sv
// Directed bench for trng_ctrl: sequencing, packing, backpressure, health failure,
// word-budget reseed, abort, async reset and reseed pulses, checked at fixed cycles.
module tb_trng_ctrl;
   localparam int WORD_W = 8;

   logic              clk = 1'b0;
   logic              rst, en, reseed, warbler_i, out_ready;
   logic              load_en, init_en, run_en, nlfsr3_ce, out_valid, busy, hlth_fail;
   logic [WORD_W-1:0] out_data;
   logic [7:0]        fail_cnt;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit bitq[$];

   always #5 clk = ~clk;

   trng_ctrl #(
      .WORD_W(8), .LOAD_CYC(4), .INIT_CYC(6), .CE_DIV(2), .RESEED_WORDS(3), .REP_LIMIT(5)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .reseed(reseed), .warbler_i(warbler_i),
      .load_en(load_en), .init_en(init_en), .run_en(run_en), .nlfsr3_ce(nlfsr3_ce),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .hlth_fail(hlth_fail), .fail_cnt(fail_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end else begin
         $display("ok   %s = 0x%0h (cycle %0d)", tag, obs, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) tick();
   endtask

   task automatic push_word(input logic [WORD_W-1:0] w);
      for (int i = WORD_W - 1; i >= 0; i--) bitq.push_back(w[i]);
   endtask

   // Present the next bit mid-cycle after every ce pulse; it is sampled on the following cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (nlfsr3_ce === 1'b1 && bitq.size() != 0) warbler_i = bitq.pop_front();
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] e;
      rst = 1'b1; en = 1'b0; reseed = 1'b0; warbler_i = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_enables", {load_en, init_en, run_en, nlfsr3_ce}, 0);
      check_eq("rst_flags", {out_valid, busy, hlth_fail}, 0);
      check_eq("rst_data", out_data, 0);
      check_eq("rst_fail_cnt", fail_cnt, 0);
      rst = 1'b0;
      push_word(8'hB2);
      push_word(8'h69);
      push_word(8'hCC);
      tick();
      check_eq("idle_busy", busy, 0);

      // Phase sequencing: en seen at edge 0
      en = 1'b1;
      cyc = 0;
      for (int c = 1; c <= 14; c++) begin
         tick();
         e = (c <= 4) ? 4'b1000 : (c <= 10) ? 4'b0100 : ((c % 2) == 0) ? 4'b0011 : 4'b0010;
         check_eq("phase", {load_en, init_en, run_en, nlfsr3_ce}, 32'(e));
      end

      // First word, consumer not ready
      run_to(28); check_eq("w1_pending", out_valid, 0);
      run_to(29); check_eq("w1_valid", out_valid, 1);
      check_eq("w1_data", out_data, 8'hB2);

      // Backpressure: second word full, ce stalled
      run_to(44); check_eq("stall_run_ce_vld", {run_en, nlfsr3_ce, out_valid}, 3'b101);
      check_eq("stall_data", out_data, 8'hB2);
      run_to(47); check_eq("stall_ce_hold", nlfsr3_ce, 0);
      check_eq("stall_data_hold", out_data, 8'hB2);
      tick();
      out_ready = 1'b1;
      #1;
      check_eq("ce_resume", nlfsr3_ce, 1);
      run_to(49); check_eq("w2_valid", out_valid, 1);
      check_eq("w2_data", out_data, 8'h69);
      run_to(50); check_eq("w2_accepted", out_valid, 0);
      out_ready = 1'b0;

      // Third word triggers the word-budget reseed
      run_to(64); check_eq("w3_pre", {run_en, out_valid}, 2'b10);
      run_to(65); check_eq("budget_load", {load_en, init_en, run_en}, 3'b100);
      check_eq("w3_valid", out_valid, 1);
      check_eq("w3_data", out_data, 8'hCC);
      for (int i = 0; i < 5; i++) bitq.push_back(1'b1);
      run_to(68); check_eq("budget_load_end", {load_en, init_en, run_en}, 3'b100);
      run_to(69); check_eq("budget_init", {load_en, init_en, run_en}, 3'b010);
      run_to(74); check_eq("budget_init_end", {init_en, out_valid}, 2'b11);
      check_eq("w3_data_held", out_data, 8'hCC);
      run_to(75); check_eq("budget_run", {load_en, init_en, run_en}, 3'b001);
      run_to(76); check_eq("w3_still_valid", out_valid, 1);
      out_ready = 1'b1;
      run_to(77); check_eq("w3_accepted", out_valid, 0);

      // Health failure: five equal captures at edges 77..85
      run_to(85); check_eq("hf_pre", {run_en, hlth_fail}, 2'b10);
      check_eq("hf_pre_cnt", fail_cnt, 0);
      run_to(86); check_eq("hf_load", {load_en, run_en}, 2'b10);
      check_eq("hf_sticky", hlth_fail, 1);
      check_eq("hf_cnt", fail_cnt, 1);
      check_eq("hf_no_word", out_valid, 0);

      // Abort from INIT
      run_to(91); check_eq("abort_init", {load_en, init_en, run_en}, 3'b010);
      en = 1'b0;
      run_to(92); check_eq("abort_idle", {busy, load_en, init_en, run_en}, 0);
      check_eq("hf_kept", hlth_fail, 1);

      // Restart, fill one word, then async reset while it is pending
      out_ready = 1'b0;
      push_word(8'hA5);
      en = 1'b1;
      run_to(93);  check_eq("restart_load", {busy, load_en}, 2'b11);
      run_to(103); check_eq("restart_run", {init_en, run_en}, 2'b01);
      run_to(120); check_eq("w4_pending", out_valid, 0);
      run_to(121); check_eq("w4_valid", out_valid, 1);
      check_eq("w4_data", out_data, 8'hA5);
      #2;
      rst = 1'b1;
      #1;
      check_eq("async_rst_flags", {out_valid, busy, hlth_fail, load_en, init_en, run_en, nlfsr3_ce}, 0);
      check_eq("async_rst_data", out_data, 0);
      check_eq("async_rst_cnt", fail_cnt, 0);

      // Reseed pulses: ignored in LOAD, honoured in RUN
      @(posedge clk);
      #1;
      rst = 1'b0;
      en = 1'b0;
      tick();
      en = 1'b1;
      cyc = 0;
      tick();
      check_eq("rs_load", load_en, 1);
      reseed = 1'b1;
      tick();
      reseed = 1'b0;
      run_to(4);  check_eq("rs_ignored_load", {load_en, init_en}, 2'b10);
      run_to(5);  check_eq("rs_ignored_init", {load_en, init_en}, 2'b01);
      run_to(11); check_eq("rs_run", run_en, 1);
      reseed = 1'b1;
      tick();
      reseed = 1'b0;
      check_eq("rs_to_load", {load_en, init_en, run_en, nlfsr3_ce}, 4'b1000);
      run_to(15); check_eq("rs_load_end", load_en, 1);
      run_to(16); check_eq("rs_init", init_en, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
